puf_response_reader: RTL and testbench
======================================

# puf_response_reader

Challenge sequencer and response reader for the ring-oscillator PUF array. Drives the pair of 5-bit oscillator selects, enables the oscillators, and counts synchronized rising edges of the two muxed oscillator outputs over a fixed clock window. It then compares the counts to derive one response bit per oscillator pair and returns a multi-bit response over a valid/ready handshake. It sits between the system controller (challenge/start side) and the two oscillator banks with their 32:1 muxes.

## Interface
- WINDOW_CYCLES, 1024: measurement window length in clk cycles (≥ 8).
- CNT_W, 16: edge-counter width; counters saturate at all-ones.
- RESP_BITS, 8: response bits produced per challenge (1..16).

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new response; sampled only in IDLE.
- challenge  in  5  base oscillator index, captured when start is accepted.
- ro_a  in  1  raw muxed output of oscillator bank A (asynchronous to clk).
- ro_b  in  1  raw muxed output of oscillator bank B (asynchronous to clk).
- sel_a  out  5  bank A oscillator select.
- sel_b  out  5  bank B oscillator select.
- osc_en  out  1  oscillator enable.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- response  out  RESP_BITS  response word; bit k is the result for pair k.

## Operation
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- **IDLE**
  - All outputs are 0; osc_en is 0.
  - start=1 captures `challenge` into `base`, clears `response`, sets bit index k=0, and moves to SETTLE.
- **Select generation (all non-IDLE states)**
  - sel_a = (base + 2k) mod 32.
  - sel_b = (base + 2k + 1) mod 32.
  - Indices wrap at 32. Example: base=31, k=0 gives sel_a=31, sel_b=0.
- **SETTLE (exactly 4 cycles)**
  - osc_en=1.
  - Edge counters cnt_a and cnt_b are held at 0.
  - The synchronizers are flushed so a select change cannot produce a counted edge.
- **MEASURE (exactly WINDOW_CYCLES cycles)**
  - ro_a and ro_b each pass through a 2-flop synchronizer and then a rising-edge detector.
  - Each detected edge increments the matching counter.
  - Counters saturate at 2^CNT_W−1; there is no wrap.
- **COMPARE (1 cycle)**
  - response[k] = (cnt_a > cnt_b). A tie gives 0.
  - If k = RESP_BITS−1, go to DONE; otherwise k increments and the FSM returns to SETTLE.
- **DONE**
  - osc_en=0 and resp_valid=1; response is held stable.
  - On resp_valid & resp_ready, go to IDLE. resp_valid drops on the next cycle.
- start is ignored while busy=1; it is not queued.
- Usage constraint: oscillator frequency must be < clk/2 for exact counts. Faster oscillators alias, and this is not flagged.
- When rst_n is asserted mid-operation, the block returns to IDLE immediately and clears all outputs and counters. The partial response is discarded.

## Timing
- Accept: start is sampled at clock edge N in IDLE. busy and osc_en go high after edge N, and SETTLE occupies the first cycle after edge N.
- Per-bit cost: 4 + WINDOW_CYCLES + 1 = WINDOW_CYCLES+5 cycles.
- resp_valid rises at edge N + RESP_BITS×(WINDOW_CYCLES+5) (majority disabled).
- Selects change only on the COMPARE→SETTLE edge, so they stay constant through each SETTLE and MEASURE.
- resp_ready held high before DONE: the handshake completes in the first DONE cycle, so resp_valid is high for exactly 1 cycle.
- Back-to-back responses: start sampled in the first IDLE cycle after the handshake is accepted.

## Configuration
- PUF_READER_MAJORITY_EN defined:
  - Each bit is measured 3 times (3 SETTLE/MEASURE/COMPARE passes with the same selects).
  - response[k] is the majority of the three comparisons.
  - Per-bit cost becomes 3×(WINDOW_CYCLES+5).
- Undefined: single measurement per bit, as described above.

## Test plan
- WINDOW_CYCLES=64, RESP_BITS=1, challenge=0; ro_a period 4 clk, ro_b period 8 clk -> cnt_a=16, cnt_b=8, response=1'b1, resp_valid at start edge + 69.
- Same setup with ro_a and ro_b swapped -> response=0. With identical periods (tie) -> response=0.
- RESP_BITS=8, challenge=31 -> select pairs observed as (31,0), (1,2), (3,4) … (13,14); ro stimulus keyed to sel gives alternating bits -> response=8'hAA.
- CNT_W=4, ro_a period 2 clk, WINDOW_CYCLES=64 -> cnt_a saturates at 15 with no wrap; ro_b silent -> response bit = 1.
- resp_ready held low 10 cycles in DONE -> resp_valid and response stable throughout; start pulses during busy are ignored; rst_n low mid-MEASURE -> next cycle busy=0, osc_en=0, response=0.
- PUF_READER_MAJORITY_EN, RESP_BITS=1: ro_a faster in passes 1 and 3, slower in pass 2 -> response=1; resp_valid at start edge + 3×69.

Source files
------------

// File: rtl/puf_reader_if.sv
// Controller-side bus of the PUF response reader.
//
// Handshake: the reader raises resp_valid with response stable and holds both
// until it samples resp_valid & resp_ready high on a clk edge; resp_valid
// drops in the following cycle. start is a request sampled only while busy
// is low; while busy is high it is ignored and not queued.
interface puf_reader_if #(
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [4:0]           challenge;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] response;

    // System controller side.
    modport master (
        output start, challenge, resp_ready,
        input  busy, resp_valid, response
    );

    // Response reader side.
    modport slave (
        input  start, challenge, resp_ready,
        output busy, resp_valid, response
    );
endinterface

// File: rtl/puf_response_reader.sv
// Ring-oscillator PUF challenge sequencer and response reader.
// For each response bit k it selects oscillator pair (base+2k, base+2k+1),
// lets the muxes settle, counts synchronized rising edges of both muxed
// outputs over a fixed window and records response[k] = (cnt_a > cnt_b).
// Optional build macro PUF_READER_MAJORITY_EN: each bit is measured three
// times with the same selects and the majority of the three results is kept.
module puf_response_reader #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16,
    parameter int RESP_BITS     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    puf_reader_if.slave host,
    input  logic       ro_a,
    input  logic       ro_b,
    output logic [4:0] sel_a,
    output logic [4:0] sel_b,
    output logic       osc_en,
    output logic [2:0] state_o
);
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(3);
    localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
    localparam logic [3:0]    K_LAST      = 4'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    logic [4:0]           base_q;
    logic [3:0]           k_q;
    logic [TW-1:0]        timer_q;
    logic [CNT_W-1:0]     cnt_a_q;
    logic [CNT_W-1:0]     cnt_b_q;
    logic [1:0]           sync_a_q;
    logic [1:0]           sync_b_q;
    logic                 prev_a_q;
    logic                 prev_b_q;
    logic [RESP_BITS-1:0] response_q;
    logic                 busy_q;
    logic                 resp_valid_q;

    logic                 rise_a;
    logic                 rise_b;
    logic                 a_gt_b;
    logic                 bit_val;
    logic [3:0]           k_inc;
    logic [4:0]           sel_a_d;
    logic [RESP_BITS-1:0] bit_mask;

`ifdef PUF_READER_MAJORITY_EN
    logic [1:0]           pass_q;
    logic [1:0]           votes_q;
    logic [1:0]           vote_total;

    // Majority of three: current comparison plus the two stored votes.
    assign vote_total = votes_q + {1'b0, a_gt_b};
    assign bit_val    = (vote_total >= 2'd2);
`else
    assign bit_val    = a_gt_b;
`endif

    // Edge detectors look at the synchronized level against its previous value.
    assign rise_a   = sync_a_q[1] & ~prev_a_q;
    assign rise_b   = sync_b_q[1] & ~prev_b_q;
    assign a_gt_b   = (cnt_a_q > cnt_b_q);
    assign k_inc    = k_q + 4'd1;
    assign sel_a_d  = base_q + {k_inc, 1'b0};
    assign bit_mask = RESP_BITS'(bit_val) << k_q;

    assign host.busy       = busy_q;
    assign host.resp_valid = resp_valid_q;
    assign host.response   = response_q;
    assign state_o         = state_q;

    // Sequencer, synchronizers, edge counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            k_q          <= '0;
            timer_q      <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            sync_a_q     <= '0;
            sync_b_q     <= '0;
            prev_a_q     <= 1'b0;
            prev_b_q     <= 1'b0;
            response_q   <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            osc_en       <= 1'b0;
            sel_a        <= '0;
            sel_b        <= '0;
`ifdef PUF_READER_MAJORITY_EN
            pass_q       <= '0;
            votes_q      <= '0;
`endif
        end else begin
            // Synchronizers run in every active state; during SETTLE this
            // flushes levels from the previous select before counting starts.
            if (state_q == S_IDLE) begin
                sync_a_q <= '0;
                sync_b_q <= '0;
                prev_a_q <= 1'b0;
                prev_b_q <= 1'b0;
            end else begin
                sync_a_q <= {sync_a_q[0], ro_a};
                sync_b_q <= {sync_b_q[0], ro_b};
                prev_a_q <= sync_a_q[1];
                prev_b_q <= sync_b_q[1];
            end

            case (state_q)
                S_IDLE: begin
                    if (host.start) begin
                        base_q     <= host.challenge;
                        k_q        <= '0;
                        timer_q    <= '0;
                        cnt_a_q    <= '0;
                        cnt_b_q    <= '0;
                        response_q <= '0;
                        sel_a      <= host.challenge;
                        sel_b      <= host.challenge + 5'd1;
                        osc_en     <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef PUF_READER_MAJORITY_EN
                        pass_q     <= '0;
                        votes_q    <= '0;
`endif
                        state_q    <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    if (timer_q == SETTLE_LAST) begin
                        timer_q <= '0;
                        state_q <= S_MEASURE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_MEASURE: begin
                    // Counters stick at all-ones rather than wrapping.
                    if (rise_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 1'b1;
                    if (rise_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 1'b1;
                    if (timer_q == WINDOW_LAST) begin
                        timer_q <= '0;
                        state_q <= S_COMPARE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_COMPARE: begin
                    timer_q <= '0;
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
`ifdef PUF_READER_MAJORITY_EN
                    if (pass_q != 2'd2) begin
                        // Repeat the measurement on the same pair.
                        pass_q  <= pass_q + 2'd1;
                        votes_q <= vote_total;
                        state_q <= S_SETTLE;
                    end else begin
                        pass_q     <= '0;
                        votes_q    <= '0;
                        response_q <= response_q | bit_mask;
                        if (k_q == K_LAST) begin
                            osc_en       <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            k_q     <= k_inc;
                            sel_a   <= sel_a_d;
                            sel_b   <= sel_a_d + 5'd1;
                            state_q <= S_SETTLE;
                        end
                    end
`else
                    response_q <= response_q | bit_mask;
                    if (k_q == K_LAST) begin
                        osc_en       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        k_q     <= k_inc;
                        sel_a   <= sel_a_d;
                        sel_b   <= sel_a_d + 5'd1;
                        state_q <= S_SETTLE;
                    end
`endif
                end

                S_DONE: begin
                    // Response stays stable until the consumer takes it.
                    if (host.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        response_q   <= '0;
                        sel_a        <= '0;
                        sel_b        <= '0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: oscillator outputs are synthesized from a
// per-index period table keyed on the live selects; expected responses come
// from edge counts computed arithmetically (window / period, saturated).
module tb_puf_response_reader;
    localparam int W    = 64;
    localparam int CW   = 5;
    localparam int RB   = 8;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PUF_READER_MAJORITY_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif
    localparam int LAT = RB * (W + 5) * PASSES;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    logic [4:0] sel_a;
    logic [4:0] sel_b;
    logic       osc_en;
    logic [2:0] dbg_state;

    puf_reader_if #(.RESP_BITS(RB)) bus ();

    puf_response_reader #(
        .WINDOW_CYCLES(W),
        .CNT_W        (CW),
        .RESP_BITS    (RB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .host   (bus),
        .ro_a   (ro_a),
        .ro_b   (ro_b),
        .sel_a  (sel_a),
        .sel_b  (sel_b),
        .osc_en (osc_en),
        .state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          per_tab[32];
    int unsigned cyc = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  sel_log[$];
    logic [9:0]  last_sel;
    bit          have_sel = 0;

    function automatic logic ro_level(int per, int unsigned c);
        if (per == 0) return 1'b0;
        return ((c % per) < (per / 2));
    endfunction

    // Oscillator models: square waves whose period follows the selected index.
    always @(negedge clk) begin
        cyc  = cyc + 1;
        ro_a = ro_level(per_tab[sel_a], cyc);
        ro_b = ro_level(per_tab[sel_b], cyc);
    end

    // Record each distinct select pair presented while busy.
    always @(negedge clk) begin
        if (bus.busy) begin
            if (!have_sel || ({sel_a, sel_b} != last_sel)) sel_log.push_back({sel_a, sel_b});
            last_sel = {sel_a, sel_b};
            have_sel = 1;
        end else begin
            have_sel = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_cnt(int per);
        int c;
        if (per == 0) return 0;
        c = W / per;
        return (c > MAXC) ? MAXC : c;
    endfunction

    function automatic logic [RB-1:0] ref_resp(logic [4:0] base);
        logic [RB-1:0] r;
        int a, b;
        r = '0;
        for (int k = 0; k < RB; k++) begin
            a = (int'(base) + 2 * k) % 32;
            b = (a + 1) % 32;
            r[k] = (ref_cnt(per_tab[a]) > ref_cnt(per_tab[b]));
        end
        return r;
    endfunction

    task automatic set_pair(input int base, input int k, input int pa, input int pb);
        per_tab[(base + 2 * k) % 32]     = pa;
        per_tab[(base + 2 * k + 1) % 32] = pb;
    endtask

    task automatic fill(input int base, input int pa, input int pb);
        for (int k = 0; k < RB; k++) set_pair(base, k, pa, pb);
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic do_req(input logic [4:0] ch, input int hold, input bit poke);
        logic [RB-1:0] exp_r;
        int n, a;
        exp_r = ref_resp(ch);
        exp_q.delete();
        for (int k = 0; k < RB; k++) begin
            a = (int'(ch) + 2 * k) % 32;
            exp_q.push_back({5'(a), 5'((a + 1) % 32)});
        end
        sel_log.delete();
        bus.challenge  = ch;
        bus.start      = 1'b1;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        check("osc_en_after_accept", osc_en, 1);
        check("first_sel_a", sel_a, ch);
        n = 0;
        while (!bus.resp_valid && n < LAT + 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus.start = poke && (n % 50 == 7);
        end
        bus.start = 1'b0;
        check("valid_latency", n, LAT);
        check("response", bus.response, exp_r);
        check("osc_en_done", osc_en, 0);
        check("sel_pair_count", sel_log.size(), RB);
        for (int i = 0; i < RB && i < sel_log.size(); i++) check("sel_pair", sel_log[i], exp_q[i]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("valid_held", bus.resp_valid, 1);
            check("response_held", bus.response, exp_r);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("valid_drop", bus.resp_valid, 0);
        check("busy_idle", bus.busy, 0);
        check("response_idle", bus.response, 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.challenge  = '0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 32; i++) per_tab[i] = 0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.resp_valid, 0);
        check("rst_osc_en", osc_en, 0);
        check("rst_response", bus.response, 0);
        check("rst_sel", {sel_a, sel_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A faster than B, B faster than A, tie.
        fill(0, 4, 8);
        do_req(5'd0, 0, 0);
        fill(0, 8, 4);
        do_req(5'd0, 0, 0);
        fill(0, 4, 4);
        do_req(5'd0, 0, 0);

        // Wrapping selects with alternating bits; stall the consumer and poke start.
        for (int k = 0; k < RB; k++) begin
            if (k % 2 == 1) set_pair(31, k, 4, 8);
            else            set_pair(31, k, 8, 4);
        end
        check("model_aa", ref_resp(5'd31), 8'hAA);
        do_req(5'd31, 10, 1);
        repeat (3) begin
            @(negedge clk);
            check("start_not_queued", bus.busy, 0);
        end

        // Saturation: period 2 against silent, itself, and period 4.
        for (int k = 0; k < RB; k++) begin
            case (k % 3)
                0:       set_pair(5, k, 2, 0);
                1:       set_pair(5, k, 2, 2);
                default: set_pair(5, k, 2, 4);
            endcase
        end
        do_req(5'd5, 0, 0);

        // Randomized tables and challenges, back to back.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) begin
                case ($urandom_range(0, 4))
                    0:       per_tab[i] = 0;
                    1:       per_tab[i] = 2;
                    2:       per_tab[i] = 4;
                    3:       per_tab[i] = 8;
                    default: per_tab[i] = 16;
                endcase
            end
            do_req(5'($urandom_range(0, 31)), $urandom_range(0, 3), 0);
        end

        // Reset in the middle of a measurement.
        fill(3, 4, 8);
        bus.challenge = 5'd3;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_osc_en", osc_en, 0);
        check("midrst_response", bus.response, 0);
        check("midrst_valid", bus.resp_valid, 0);
        @(negedge clk);
        check("midrst_busy_next", bus.busy, 0);
        check("midrst_sel", {sel_a, sel_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        fill(9, 8, 2);
        do_req(5'd9, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
